// File: rtl/gmp_pkg.sv
// Shared types and helpers for the GMP data/stuff decision generator.
// Holds the FSM state type, the default widths and the residue step.
package gmp_pkg;

    // Default width of pm/cm and of the residue (one extra bit so that
    // r + cm never overflows before the conditional subtract).
    localparam int GMP_MPT_W = 8;
    localparam int GMP_RES_W = GMP_MPT_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gmp_state_t;

    // One step of the residue recurrence: (r + cm) mod pm.
    // Valid as long as r < pm and cm <= pm, so a single subtract is enough.
    function automatic logic [31:0] gmp_step(input logic [31:0] r,
                                             input logic [31:0] cm,
                                             input logic [31:0] pm);
        logic [31:0] s;
        s = r + cm;
        return (s >= pm) ? (s - pm) : s;
    endfunction

endpackage

// File: rtl/gmp_lane_chain.sv
// Combinational residue chain for LANES consecutive payload positions.
// Lane k covers position pos+k+1; it carries data when its residue is
// below cm and the position lies inside the frame.
module gmp_lane_chain
    import gmp_pkg::*;
#(
    parameter int MPT_W = GMP_MPT_W,
    parameter int LANES = 4
) (
    input  logic [MPT_W:0]   r_in,
    input  logic [MPT_W:0]   pos,
    input  logic [MPT_W-1:0] pm,
    input  logic [MPT_W-1:0] cm,
    output logic [LANES-1:0] ds,
    output logic [LANES-1:0] lane_mask,
    output logic [MPT_W:0]   r_out
);

    localparam int RES_W = MPT_W + 1;

    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] p;

    // Walk the residue lane by lane and classify each position.
    always_comb begin
        acc       = r_in;
        p         = '0;
        ds        = '0;
        lane_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            acc          = RES_W'(gmp_step(32'(acc), 32'(cm), 32'(pm)));
            p            = pos + RES_W'(k + 1);
            lane_mask[k] = (p <= {1'b0, pm});
            ds[k]        = (acc < {1'b0, cm}) && lane_mask[k];
        end
        r_out = acc;
    end

endmodule

// File: rtl/gmp_ds_gen_multi.sv
// Multi-lane GMP data/stuff generator.
// On each requested beat it emits LANES decisions (lane 0 earliest), a
// mask of lanes that hold real positions, frame start/end markers, and
// pulses for SOF protocol errors and illegal frame parameters.
// Optional build macro GMP_DS_CNT_EN adds a per-frame data counter
// (data_cnt) and a pulse (err_cnt) when the frame total differs from cm.
module gmp_ds_gen_multi
    import gmp_pkg::*;
#(
    parameter int MPT_W = GMP_MPT_W,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MPT_W-1:0] pm,
    input  logic [MPT_W-1:0] cm,
    input  logic             sof,
    input  logic             valid_in,
    output logic             sof_out,
    output logic             valid_out,
    output logic [LANES-1:0] ds,
    output logic [LANES-1:0] lane_mask,
    output logic             eof_out,
    output logic             err_sof_early,
    output logic             err_sof_late,
    output logic             err_param
`ifdef GMP_DS_CNT_EN
    ,
    output logic [MPT_W-1:0] data_cnt,
    output logic             err_cnt
`endif
);

    localparam int RES_W = MPT_W + (GMP_RES_W - GMP_MPT_W);
    localparam logic [RES_W-1:0] LANES_R = RES_W'(LANES);

    gmp_state_t state_q, state_n;

    logic [RES_W-1:0] r_q, r_n;
    logic [RES_W-1:0] pos_q, pos_n;
    logic [RES_W-1:0] pos_adv;
    logic [MPT_W-1:0] pm_q, pm_n;
    logic [MPT_W-1:0] cm_q, cm_n;

    logic             sof_out_n, valid_out_n, eof_out_n;
    logic             err_early_n, err_late_n, err_param_n;
    logic [LANES-1:0] ds_n, mask_n;

    logic [LANES-1:0] ds_c, mask_c;
    logic [RES_W-1:0] r_c;
    logic             param_bad;
    logic             beat_last;

`ifdef GMP_DS_CNT_EN
    logic [MPT_W-1:0] cnt_n;
    logic [MPT_W-1:0] beat_pop;
    logic             err_cnt_n;
`endif

    gmp_lane_chain #(
        .MPT_W (MPT_W),
        .LANES (LANES)
    ) u_chain (
        .r_in      (r_q),
        .pos       (pos_q),
        .pm        (pm_q),
        .cm        (cm_q),
        .ds        (ds_c),
        .lane_mask (mask_c),
        .r_out     (r_c)
    );

    // Frame-parameter legality and end-of-frame detection for this beat.
    always_comb begin
        param_bad = (pm == '0) || (cm > pm);
        pos_adv   = pos_q + LANES_R;
        beat_last = (pos_adv >= {1'b0, pm_q});
    end

`ifdef GMP_DS_CNT_EN
    // Number of data lanes in the beat being produced.
    always_comb begin
        beat_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_pop = beat_pop + MPT_W'(ds_c[k]);
        end
    end
`endif

    // Next-state and next-output decode for the IDLE/RUN controller.
    always_comb begin
        state_n     = state_q;
        r_n         = r_q;
        pos_n       = pos_q;
        pm_n        = pm_q;
        cm_n        = cm_q;
        sof_out_n   = 1'b0;
        valid_out_n = 1'b0;
        eof_out_n   = 1'b0;
        err_early_n = 1'b0;
        err_late_n  = 1'b0;
        err_param_n = 1'b0;
        ds_n        = ds;
        mask_n      = lane_mask;
`ifdef GMP_DS_CNT_EN
        cnt_n       = data_cnt;
        err_cnt_n   = 1'b0;
`endif

        if (sof) begin
            // A parameter beat restarts the frame from either state; any
            // valid_in presented alongside it is deliberately dropped.
            err_early_n = (state_q == RUN);
            pm_n        = pm;
            cm_n        = cm;
            r_n         = '0;
            pos_n       = '0;
`ifdef GMP_DS_CNT_EN
            cnt_n       = '0;
`endif
            if (param_bad) begin
                err_param_n = 1'b1;
                state_n     = IDLE;
            end else begin
                state_n     = RUN;
            end
        end else if (valid_in) begin
            if (state_q == IDLE) begin
                err_late_n = 1'b1;
            end else begin
                valid_out_n = 1'b1;
                sof_out_n   = (pos_q == '0);
                ds_n        = ds_c;
                mask_n      = mask_c;
                r_n         = r_c;
                pos_n       = pos_adv;
`ifdef GMP_DS_CNT_EN
                cnt_n       = data_cnt + beat_pop;
`endif
                if (beat_last) begin
                    eof_out_n = 1'b1;
                    state_n   = IDLE;
`ifdef GMP_DS_CNT_EN
                    err_cnt_n = (cnt_n != cm_q);
`endif
                end
            end
        end
    end

    // State, frame context and registered outputs; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            r_q           <= '0;
            pos_q         <= '0;
            pm_q          <= '0;
            cm_q          <= '0;
            sof_out       <= 1'b0;
            valid_out     <= 1'b0;
            eof_out       <= 1'b0;
            err_sof_early <= 1'b0;
            err_sof_late  <= 1'b0;
            err_param     <= 1'b0;
            ds            <= '0;
            lane_mask     <= '0;
`ifdef GMP_DS_CNT_EN
            data_cnt      <= '0;
            err_cnt       <= 1'b0;
`endif
        end else begin
            state_q       <= state_n;
            r_q           <= r_n;
            pos_q         <= pos_n;
            pm_q          <= pm_n;
            cm_q          <= cm_n;
            sof_out       <= sof_out_n;
            valid_out     <= valid_out_n;
            eof_out       <= eof_out_n;
            err_sof_early <= err_early_n;
            err_sof_late  <= err_late_n;
            err_param     <= err_param_n;
            ds            <= ds_n;
            lane_mask     <= mask_n;
`ifdef GMP_DS_CNT_EN
            data_cnt      <= cnt_n;
            err_cnt       <= err_cnt_n;
`endif
        end
    end

endmodule
